dmem_responder: RTL and testbench

Data-side responder for the single-cycle ARM core's memory bus: it answers the core's `MemWrite`/`DataAdr`/`WriteData` requests with a word RAM plus a small memory-mapped status window. It latches a pass/fail verdict from the first store to the done address and keeps hardware cycle and store counters. It also buffers every accepted store in a log FIFO that a bench or debug port drains through a valid/ready handshake. It sits between `top`'s datapath and any checker, replacing ad-hoc bus snooping.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/store_log_fifo.sv | 46 ++++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and MMIO offsets for the data-side responder.
// Offsets are relative to the verdict register base address.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } verdict_t;

    localparam logic [31:0] OFS_VERDICT = 32'h0;
    localparam logic [31:0] OFS_CYCLES  = 32'h4;
    localparam logic [31:0] OFS_STORES  = 32'h8;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } log_entry_t;

endpackage

// File: rtl/store_log_fifo.sv
// Show-ahead FIFO: head visible the cycle after the first push; reads 0 when empty.
// Push while full is dropped unless a pop happens in the same cycle.
module store_log_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, verdict/counter MMIO window and a store log.
// Reads are combinational; verdict and log head appear one cycle after the store.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 32,
    parameter logic [31:0] DONE_ADR  = 32'd128,
    parameter logic [31:0] EXPECTED  = 32'hFE,
    parameter int          LOG_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic        log_overflow
);

    localparam int          RAM_AW      = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES   = 32'(4 * RAM_WORDS);
    localparam logic [31:0] VERDICT_ADR = DONE_ADR + OFS_VERDICT;
    localparam logic [31:0] CYCLES_ADR  = DONE_ADR + OFS_CYCLES;
    localparam logic [31:0] STORES_ADR  = DONE_ADR + OFS_STORES;

    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              in_ram;
    logic              hit_verdict;
    logic              hit_cycles;
    logic              hit_stores;
    logic              accept;

    verdict_t          state_q;
    verdict_t          state_d;
    logic [31:0]       cycle_cnt;
    logic [31:0]       store_cnt;

    log_entry_t        push_entry;
    log_entry_t        head;
    logic              fifo_full;

    assign ram_idx     = DataAdr[RAM_AW+1:2];
    assign in_ram      = (DataAdr < RAM_BYTES);
    assign hit_verdict = (DataAdr[31:2] == VERDICT_ADR[31:2]);
    assign hit_cycles  = (DataAdr[31:2] == CYCLES_ADR[31:2]);
    assign hit_stores  = (DataAdr[31:2] == STORES_ADR[31:2]);
    // Misaligned stores vanish entirely: no RAM write, no log entry, no count.
    assign accept      = MemWrite && (DataAdr[1:0] == 2'b00);

    always_comb begin
        ReadData = '0;
        if (in_ram)           ReadData = ram[ram_idx];
        else if (hit_verdict) ReadData = {30'b0, pass, done};
        else if (hit_cycles)  ReadData = cycle_cnt;
        else if (hit_stores)  ReadData = store_cnt;
    end

    always_ff @(posedge clk) begin
        if (!reset && accept && in_ram) ram[ram_idx] <= WriteData;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && accept && hit_verdict) begin
            state_d = (WriteData == EXPECTED) ? ST_PASS : ST_FAIL;
        end
    end

    assign done = (state_q != ST_RUN);
    assign pass = (state_q == ST_PASS);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            store_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (accept) store_cnt <= store_cnt + 32'd1;
        end
    end

    assign push_entry = '{adr: DataAdr, data: WriteData};

    store_log_fifo #(
        .WIDTH (64),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (push_entry),
        .pop   (log_ready),
        .dout  (head),
        .valid (log_valid),
        .full  (fifo_full)
    );

    assign log_adr  = head.adr;
    assign log_data = head.data;

    // A same-cycle pop frees a slot, so only a push into a full, non-draining log drops.
    always_ff @(posedge clk) begin
        if (reset)
            log_overflow <= 1'b0;
        else if (accept && fifo_full && !(log_ready && log_valid))
            log_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, verdict, counters and store-log behaviour.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        done;
    logic        pass;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_adr;
    logic [31:0] log_data;
    logic        log_overflow;

    int n_pass  = 0;
    int n_total = 0;

    dmem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .done         (done),
        .pass         (pass),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_adr      (log_adr),
        .log_data     (log_data),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        DataAdr = adr;
        #1;
        check(tag, ReadData, exp);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] adr, input logic [31:0] data);
        check({tag, "_vld"}, {31'b0, log_valid}, 32'd1);
        check({tag, "_adr"}, log_adr, adr);
        check({tag, "_dat"}, log_data, data);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; log_ready = 1'b0;
        tick();
        tick();
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_pass", {31'b0, pass}, 32'd0);
        check("rst_lvld", {31'b0, log_valid}, 32'd0);
        check("rst_ovf",  {31'b0, log_overflow}, 32'd0);
        check("rst_ladr", log_adr, 32'd0);
        check("rst_ldat", log_data, 32'd0);
        read_check("rst_cyc", 32'd132, 32'd0);
        read_check("rst_str", 32'd136, 32'd0);
        reset = 1'b0;

        // Basic store, readback and log head.
        store(32'h10, 32'h11);
        read_check("ram_10", 32'h10, 32'h11);
        read_check("ram_10_lowbits", 32'h12, 32'h11);
        read_check("str_cnt1", 32'd136, 32'd1);
        read_check("cyc_cnt1", 32'd132, 32'd1);
        read_check("unmapped_rd", 32'h400, 32'd0);
        pop_check("log1", 32'h10, 32'h11);
        check("log1_empty", {31'b0, log_valid}, 32'd0);

        // Pass verdict is sticky.
        store(32'd128, 32'hFE);
        check("pass_done", {31'b0, done}, 32'd1);
        check("pass_pass", {31'b0, pass}, 32'd1);
        read_check("pass_rd", 32'd128, 32'd3);
        store(32'd128, 32'h5);
        check("sticky_pass", {31'b0, pass}, 32'd1);
        pop_check("logp0", 32'd128, 32'hFE);
        pop_check("logp1", 32'd128, 32'h5);

        // Fail verdict.
        do_reset();
        check("fail_pre_done", {31'b0, done}, 32'd0);
        store(32'd128, 32'h7);
        check("fail_done", {31'b0, done}, 32'd1);
        check("fail_pass", {31'b0, pass}, 32'd0);
        read_check("fail_rd", 32'd128, 32'd1);
        store(32'd128, 32'hFE);
        check("sticky_fail", {31'b0, pass}, 32'd0);

        // Overflow: nine stores into an eight-deep log.
        do_reset();
        for (int i = 0; i < 9; i++) store(32'(4 * i), 32'h100 + 32'(i));
        check("ovf_set", {31'b0, log_overflow}, 32'd1);
        read_check("ovf_str", 32'd136, 32'd9);
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_e%0d", i), 32'(4 * i), 32'h100 + 32'(i));
        check("ovf_drained", {31'b0, log_valid}, 32'd0);

        // Full log with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 8; i++) store(32'(4 * i), 32'h200 + 32'(i));
        log_ready = 1'b1;
        store(32'h7C, 32'h2FF);
        log_ready = 1'b0;
        check("pp_noovf", {31'b0, log_overflow}, 32'd0);
        read_check("ram_top", 32'h7C, 32'h2FF);
        for (int i = 1; i < 8; i++) pop_check($sformatf("pp_e%0d", i), 32'(4 * i), 32'h200 + 32'(i));
        pop_check("pp_last", 32'h7C, 32'h2FF);
        check("pp_drained", {31'b0, log_valid}, 32'd0);

        // Misaligned and unmapped stores, then reset mid-drain.
        do_reset();
        store(32'h10, 32'hAA);
        pop_check("mis_pre", 32'h10, 32'hAA);
        store(32'h13, 32'hBB);
        read_check("mis_ram", 32'h10, 32'hAA);
        check("mis_nolog", {31'b0, log_valid}, 32'd0);
        read_check("mis_str", 32'd136, 32'd1);
        store(32'h200, 32'h1);
        read_check("unm_rd", 32'h200, 32'd0);
        read_check("unm_str", 32'd136, 32'd2);
        store(32'h14, 32'h55);
        store(32'h18, 32'h66);
        pop_check("mid_e0", 32'h200, 32'h1);
        reset = 1'b1; MemWrite = 1'b1; DataAdr = 32'h14; WriteData = 32'hCC;
        tick();
        reset = 1'b0; MemWrite = 1'b0;
        check("mid_lvld", {31'b0, log_valid}, 32'd0);
        check("mid_done", {31'b0, done}, 32'd0);
        read_check("mid_cyc", 32'd132, 32'd0);
        read_check("mid_str", 32'd136, 32'd0);
        read_check("mid_ram", 32'h14, 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
